ls_unit: RTL and testbench

Load/store initiator for the MEM stage. It accepts one load or store request from the pipeline and drives the byte-wide data memory port one byte per cycle, in big-endian order (lowest address = most significant byte). For loads it assembles and extends the result; for stores it splits the data into bytes. It holds `busy` so the pipeline stalls until `done`.

---
 rtl/ls_unit_if.sv | 29 ++
 rtl/ls_unit.sv | 152 +++++++++++++++
 tb/tb_ls_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ls_unit_if.sv
// Pipeline request/response and byte-wide data-memory signals of the MEM-stage load/store unit.
// The slave modport is the unit; the master modport is the pipeline plus memory around it.
interface ls_unit_if;
  logic        start;
  logic        rw;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  start, rw, size, signed_ld, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_en, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output start, rw, size, signed_ld, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ls_unit.sv
// MEM-stage load/store initiator: moves one byte per cycle, big-endian (lowest address = MSB),
// assembling and extending loads and splitting stores; busy stalls the pipeline until done.
module ls_unit (
  input  logic     clk,
  input  logic     reset,
  ls_unit_if.slave bus
);
  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_xfer = 2'd1,
    st_resp = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        rw_r;
  logic [1:0]  size_r;
  logic        sgn_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] sr_r;
  logic [31:0] rdata_r;
  logic [1:0]  beat_r;
  logic        err_r;
  logic [1:0]  last_s;
  logic [1:0]  sel_s;
  logic [31:0] asm_s;

  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] alo);
    case (size)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = alo[0];
      2'b10:   bad_req = (alo != 2'b00);
      default: bad_req = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size, input logic sgn);
    case (size)
      2'b00:   extend = {{24{sgn & v[7]}}, v[7:0]};
      2'b01:   extend = {{16{sgn & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  // Last beat index, store byte select (beat 0 carries the MSB) and load assembly value
  always_comb begin
    case (size_r)
      2'b00:   last_s = 2'd0;
      2'b01:   last_s = 2'd1;
      default: last_s = 2'd3;
    endcase
    sel_s = last_s - beat_r;
    asm_s = {sr_r[23:0], bus.mem_rdata};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      st_idle: begin
        if (bus.start) begin
          if (bad_req(bus.size, bus.addr[1:0])) state_s = st_resp;
          else                                  state_s = st_xfer;
        end else begin
          state_s = st_idle;
        end
      end
      st_xfer: begin
        if (beat_r == last_s) state_s = st_resp;
        else                  state_s = st_xfer;
      end
      st_resp: state_s = st_idle;
      default: state_s = st_idle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= st_idle;
    else       state_r <= state_s;
  end

  // Request latch, beat counter, load shift register and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_r    <= 1'b0;
      size_r  <= 2'b00;
      sgn_r   <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      sr_r    <= 32'd0;
      rdata_r <= 32'd0;
      beat_r  <= 2'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          if (bus.start) begin
            rw_r    <= bus.rw;
            size_r  <= bus.size;
            sgn_r   <= bus.signed_ld;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            sr_r    <= 32'd0;
            beat_r  <= 2'd0;
            err_r   <= bad_req(bus.size, bus.addr[1:0]);
          end
        end
        st_xfer: begin
          beat_r <= beat_r + 2'd1;
          if (!rw_r) begin
            sr_r <= asm_s;
            // Result updates only on the edge that enters RESP
            if (beat_r == last_s) rdata_r <= extend(asm_s, size_r, sgn_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state; the memory port is quiet outside XFER
  always_comb begin
    bus.busy      = (state_r != st_idle);
    bus.done      = (state_r == st_resp);
    bus.err       = (state_r == st_resp) & err_r;
    bus.rdata     = rdata_r;
    bus.mem_en    = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 8'd0;
    if (state_r == st_xfer) begin
      bus.mem_en   = 1'b1;
      bus.mem_rw   = rw_r;
      bus.mem_addr = addr_r + {30'd0, beat_r};
      if (rw_r) begin
        case (sel_s)
          2'd0:    bus.mem_wdata = wdata_r[7:0];
          2'd1:    bus.mem_wdata = wdata_r[15:8];
          2'd2:    bus.mem_wdata = wdata_r[23:16];
          default: bus.mem_wdata = wdata_r[31:24];
        endcase
      end else begin
        bus.mem_wdata = 8'd0;
      end
    end else begin
      bus.mem_en = 1'b0;
    end
  end
endmodule

// File: tb/tb_ls_unit.sv
// Self-checking bench for ls_unit: directed scenarios plus random requests against a
// request-level reference model (big-endian byte memory, alignment rules, extension).
module tb_ls_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ls_unit_if bus ();
  ls_unit dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0]  mem     [0:255];
  logic [7:0]  exp_mem [0:255];
  logic        mem_init;
  logic        pre_wr;
  logic [7:0]  pre_a;
  logic [7:0]  pre_d;
  logic [31:0] exp_rdata;
  int          n_chk  = 0;
  int          n_pass = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  // Byte memory: combinational read, write at the end of a write beat
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (pre_wr) begin
      mem[pre_a] <= pre_d;
    end else if (bus.mem_en && bus.mem_rw) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    int          nb;
    logic [31:0] v;
    logic [31:0] a;
    nb = 1 << size;
    v  = 32'd0;
    for (int k = 0; k < nb; k++) begin
      a = addr + 32'(k);
      v = (v << 8) | {24'd0, exp_mem[a[7:0]]};
    end
    if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_err"},    32'(bus.err),    32'd0);
    check({tag, "_rdata"},  bus.rdata,       32'd0);
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_mem_rw"}, 32'(bus.mem_rw), 32'd0);
    check({tag, "_maddr"},  bus.mem_addr,    32'd0);
    check({tag, "_mwdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_wr = 1'b1; pre_a = a; pre_d = d;
    exp_mem[a] = d;
    @(negedge clk);
    pre_wr = 1'b0;
  endtask

  task automatic req(input logic rw, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic        bad;
    int          nb;
    int          lat;
    int          beats;
    logic        got_done;
    logic [31:0] a;
    logic [31:0] b;
    bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    nb  = bad ? 0 : (1 << size);
    lat = bad ? 1 : nb + 1;
    if (!bad && !rw) exp_rdata = model_load(addr, size, sgn);
    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw; bus.size = size; bus.signed_ld = sgn;
    bus.addr = addr; bus.wdata = wdata;
    @(negedge clk);
    bus.start = 1'b0;
    beats = 0;
    got_done = 1'b0;
    for (int c = 1; c <= 10 && !got_done; c++) begin
      check("busy", 32'(bus.busy), 32'd1);
      if (bus.mem_en) begin
        if (beats < nb) begin
          a = addr + 32'(beats);
          check("mem_addr", bus.mem_addr, a);
          check("mem_rw", 32'(bus.mem_rw), 32'(rw));
          if (rw) begin
            b = wdata >> (8 * (nb - 1 - beats));
            check("mem_wdata", 32'(bus.mem_wdata), {24'd0, b[7:0]});
            exp_mem[a[7:0]] = b[7:0];
          end
        end
        beats++;
      end
      if (bus.done) begin
        got_done = 1'b1;
        check("done_cycle", 32'(c), 32'(lat));
        check("err", 32'(bus.err), 32'(bad));
        check("rdata", bus.rdata, exp_rdata);
        check("resp_mem_en", 32'(bus.mem_en), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    check("beat_count", 32'(beats), 32'(nb));
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("rdata_hold", bus.rdata, exp_rdata);
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1; pre_wr = 1'b0; pre_a = 8'd0; pre_d = 8'd0;
    bus.start = 1'b0; bus.rw = 1'b0; bus.size = 2'd0; bus.signed_ld = 1'b0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    exp_rdata = 32'd0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    mem_init = 1'b0;
    reset = 1'b0;

    // Word store then signed word load
    req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("st_w_10", 32'(mem[8'h10]), 32'hDE);
    check("st_w_11", 32'(mem[8'h11]), 32'hAD);
    check("st_w_12", 32'(mem[8'h12]), 32'hBE);
    check("st_w_13", 32'(mem[8'h13]), 32'hEF);
    req(1'b0, 2'd2, 1'b1, 32'h10, 32'd0);
    check("ld_word", bus.rdata, 32'hDEAD_BEEF);

    // Extension cases
    preload(8'h20, 8'h80);
    preload(8'h21, 8'hFF);
    req(1'b0, 2'd0, 1'b1, 32'h20, 32'd0);
    check("ld_b_s", bus.rdata, 32'hFFFF_FF80);
    req(1'b0, 2'd0, 1'b0, 32'h20, 32'd0);
    check("ld_b_u", bus.rdata, 32'h0000_0080);
    req(1'b0, 2'd1, 1'b1, 32'h20, 32'd0);
    check("ld_h_s", bus.rdata, 32'hFFFF_80FF);

    // Halfword store uses the low field
    req(1'b1, 2'd1, 1'b0, 32'h30, 32'h1234_5678);
    check("st_h_30", 32'(mem[8'h30]), 32'h56);
    check("st_h_31", 32'(mem[8'h31]), 32'h78);
    check("st_h_32", 32'(mem[8'h32]), 32'(8'(8'h32 * 7 + 3)));

    // Error requests
    req(1'b0, 2'd2, 1'b0, 32'h41, 32'd0);
    req(1'b1, 2'd1, 1'b0, 32'h43, 32'h1111_2222);
    req(1'b0, 2'd3, 1'b0, 32'h40, 32'd0);
    check("err_rdata_kept", bus.rdata, 32'hFFFF_80FF);

    // Reset during beat k=2 of a word store
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b1; bus.size = 2'd2; bus.addr = 32'h50; bus.wdata = 32'hAABB_CCDD;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_en", 32'(bus.mem_en), 32'd1);
    check("pre_reset_addr", bus.mem_addr, 32'h52);
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_mem[8'h50] = 8'hAA;
    exp_mem[8'h51] = 8'hBB;
    exp_rdata = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 8'h50; i <= 8'h53; i++) check("abort_mem", 32'(mem[i]), 32'(exp_mem[i]));
    req(1'b0, 2'd0, 1'b1, 32'h51, 32'd0);
    check("ld_after_reset", bus.rdata, 32'hFFFF_FFBB);

    // start held high through a word load
    exp_rdata = model_load(32'h10, 2'd2, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.size = 2'd2; bus.signed_ld = 1'b0; bus.addr = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("b2b_busy", 32'(bus.busy), 32'((c >= 1 && c <= 5) || (c >= 7 && c <= 11)));
      check("b2b_done", 32'(bus.done), 32'(c == 5 || c == 11));
      if (c == 5 || c == 11) check("b2b_rdata", bus.rdata, exp_rdata);
      if (c == 11) bus.start = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Address wrap at the top of the space
    req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0);
    req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D);

    // Random requests
    for (int i = 0; i < 60; i++) begin
      req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 255)), $urandom);
    end

    for (int i = 0; i < 256; i++) check("final_mem", 32'(mem[i]), 32'(exp_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
